// File: rtl/disp_scan_mux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | disp_scan_mux_pkg                                                  |
// | Segment patterns and counter-width helpers for the scan mux.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package disp_scan_mux_pkg;

  localparam int SUB_W = 3;
  localparam logic [SUB_W-1:0] SUB_MAX = 3'd7;

  // Active-high patterns, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int tick_cnt_width(input int divisor);
    return (divisor > 1) ? $clog2(divisor) : 1;
  endfunction

  function automatic int slot_idx_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/disp_scan_mux_hex_seg_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hex_seg_decoder                                                    |
// | Combinational hex nibble to active-high 7-segment pattern.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module hex_seg_decoder
  import disp_scan_mux_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_PATTERNS[hex_i];
  end

endmodule
`default_nettype wire

// File: rtl/disp_scan_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | disp_scan_mux                                                      |
// | Multiplexed 7-segment scanner with frame snapshot and PWM dimming. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module disp_scan_mux
  import disp_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIVISOR    = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic [2:0]              brightness_i,
  input  logic                    en_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_done_o
);

  localparam int CNT_W = tick_cnt_width(DIVISOR);
  localparam int IDX_W = slot_idx_width(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic INV = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]        count_q, count_d;
  logic [SUB_W-1:0]        sub_q, sub_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    load_q;
  logic [4*NUM_DIGITS-1:0] snap_digits_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q;
  logic [NUM_DIGITS-1:0]   snap_blank_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q;

  logic                    tick;
  logic                    slot_end;
  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] disp_digits;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [NUM_DIGITS-1:0]   disp_blank;
  logic [3:0]              digit_arr [NUM_DIGITS];
  logic [3:0]              cur_hex;
  logic [6:0]              cur_seg;
  logic                    lit;

  assign tick     = (count_q == CNT_MAX);
  assign slot_end = tick && (sub_q == SUB_MAX);
  assign wrap     = slot_end && (idx_q == IDX_MAX);

  always_comb begin
    count_d = tick ? '0 : count_q + 1'b1;
    sub_d   = tick ? sub_q + 1'b1 : sub_q;
    idx_d   = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // The first cycle after reset displays the values being captured into the
  // snapshot that same edge, so digit 0 gets its full first slot.
  assign disp_digits = load_q ? digits_i : snap_digits_q;
  assign disp_dp     = load_q ? dp_i     : snap_dp_q;
  assign disp_blank  = load_q ? blank_i  : snap_blank_q;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit_split
    assign digit_arr[k] = disp_digits[4*k +: 4];
  end

  assign cur_hex = digit_arr[idx_q];
  assign lit     = en_i && !disp_blank[idx_q] && (sub_q <= brightness_i);

  hex_seg_decoder u_dec (
    .hex_i (cur_hex),
    .seg_o (cur_seg)
  );

  always_comb begin
    an_d  = {NUM_DIGITS{INV}};
    seg_d = {7{INV}};
    dp_d  = INV;
    if (lit) begin
      an_d  = (NUM_DIGITS'(1) << idx_q) ^ {NUM_DIGITS{INV}};
      seg_d = cur_seg ^ {7{INV}};
      dp_d  = disp_dp[idx_q] ^ INV;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= '0;
      sub_q         <= '0;
      idx_q         <= '0;
      load_q        <= 1'b1;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_blank_q  <= '1;
      frame_done_q  <= 1'b0;
      an_q          <= {NUM_DIGITS{INV}};
      seg_q         <= {7{INV}};
      dp_q          <= INV;
    end else begin
      count_q      <= count_d;
      sub_q        <= sub_d;
      idx_q        <= idx_d;
      load_q       <= 1'b0;
      frame_done_q <= wrap;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      if (load_q || wrap) begin
        snap_digits_q <= digits_i;
        snap_dp_q     <= dp_i;
        snap_blank_q  <= blank_i;
      end
    end
  end

  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign an_o         = an_q;
  assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_disp_scan_mux                                                   |
// | Directed vector bench, 4 digits, divisor 4, active-low outputs.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_disp_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [2:0]  brightness;
  logic        en;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_done;

  always #5 clk = ~clk;

  disp_scan_mux #(
    .NUM_DIGITS (4),
    .DIVISOR    (4),
    .ACTIVE_LOW (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .digits_i     (digits),
    .dp_i         (dp),
    .blank_i      (blank),
    .brightness_i (brightness),
    .en_i         (en),
    .seg_o        (seg),
    .dp_o         (dp_out),
    .an_o         (an),
    .frame_done_o (frame_done)
  );

  typedef struct {
    int          k;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [2:0]  bright;
    logic        en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpo;
    logic        fd;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  int   k = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // k counts rising edges since reset release; sampling is 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    k++;
    #1;
  endtask

  task automatic add(input int kk, input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                     input logic [2:0] br, input logic e, input logic [3:0] a, input logic [6:0] s,
                     input logic po, input logic f);
    vec_t v;
    v.k = kk; v.digits = d; v.dp = p; v.blank = b; v.bright = br; v.en = e;
    v.an = a; v.seg = s; v.dpo = po; v.fd = f;
    vecs.push_back(v);
  endtask

  initial begin
    int bad_an;
    int bad_seg;

    rst = 1'b1; digits = 16'h4321; dp = 4'h0; blank = 4'h0; brightness = 3'd7; en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp_out), 32'h1);
    check("rst_fd", 32'(frame_done), 32'h0);
    rst = 1'b0;
    k = 0;

    //   k    digits    dp    blank  br  en   an     seg    dp fd
    add(  1, 16'h4321, 4'h0, 4'h0, 7, 1, 4'hE, 7'h79, 1, 0);
    add( 32, 16'h4321, 4'h0, 4'h0, 7, 1, 4'hE, 7'h79, 1, 0);
    add( 33, 16'h4321, 4'h0, 4'h0, 7, 1, 4'hD, 7'h24, 1, 0);
    add( 65, 16'h4321, 4'h0, 4'h0, 7, 1, 4'hB, 7'h30, 1, 0);
    add( 97, 16'h4321, 4'h0, 4'h0, 7, 1, 4'h7, 7'h19, 1, 0);
    add(127, 16'h4321, 4'h0, 4'h0, 7, 1, 4'h7, 7'h19, 1, 0);
    add(128, 16'h4321, 4'h0, 4'h0, 7, 1, 4'h7, 7'h19, 1, 1);
    add(129, 16'h4321, 4'h0, 4'h0, 7, 1, 4'hE, 7'h79, 1, 0);
    add(150, 16'hFFFF, 4'h0, 4'h0, 7, 1, 4'hE, 7'h79, 1, 0);
    add(200, 16'hFFFF, 4'h0, 4'h0, 7, 1, 4'hB, 7'h30, 1, 0);
    add(256, 16'hFFFF, 4'h0, 4'h0, 7, 1, 4'h7, 7'h19, 1, 1);
    add(257, 16'hFFFF, 4'h0, 4'h0, 7, 1, 4'hE, 7'h0E, 1, 0);
    add(260, 16'hFFFF, 4'h0, 4'h0, 0, 1, 4'hE, 7'h0E, 1, 0);
    add(261, 16'hFFFF, 4'h0, 4'h0, 0, 1, 4'hF, 7'h7F, 1, 0);
    add(288, 16'hFFFF, 4'h0, 4'h0, 0, 1, 4'hF, 7'h7F, 1, 0);
    add(289, 16'hFFFF, 4'h0, 4'h0, 0, 1, 4'hD, 7'h0E, 1, 0);
    add(320, 16'h4321, 4'h1, 4'h4, 7, 1, 4'hD, 7'h0E, 1, 0);
    add(384, 16'h4321, 4'h1, 4'h4, 7, 1, 4'h7, 7'h0E, 1, 1);
    add(385, 16'h4321, 4'h1, 4'h4, 7, 1, 4'hE, 7'h79, 0, 0);
    add(420, 16'h4321, 4'h1, 4'h4, 7, 1, 4'hD, 7'h24, 1, 0);
    add(450, 16'h4321, 4'h1, 4'h4, 7, 1, 4'hF, 7'h7F, 1, 0);
    add(481, 16'h4321, 4'h1, 4'h4, 7, 1, 4'h7, 7'h19, 1, 0);

    foreach (vecs[i]) begin
      digits = vecs[i].digits; dp = vecs[i].dp; blank = vecs[i].blank;
      brightness = vecs[i].bright; en = vecs[i].en;
      if (k >= vecs[i].k) begin
        errors++;
        $display("FAIL order@%0d: at k=%0d", vecs[i].k, k);
      end
      while (k < vecs[i].k) step();
      check($sformatf("an@%0d", k), 32'(an), 32'(vecs[i].an));
      check($sformatf("seg@%0d", k), 32'(seg), 32'(vecs[i].seg));
      check($sformatf("dp@%0d", k), 32'(dp_out), 32'(vecs[i].dpo));
      check($sformatf("fd@%0d", k), 32'(frame_done), 32'(vecs[i].fd));
    end

    // Display disable for 50 cycles mid-slot: dark immediately, scan keeps its phase.
    while (k < 500) step();
    en = 1'b0;
    bad_an = 0;
    bad_seg = 0;
    repeat (50) begin
      step();
      if (an !== 4'hF) bad_an++;
      if (seg !== 7'h7F) bad_seg++;
      if (k == 512) check("en_off_fd@512", 32'(frame_done), 32'h1);
    end
    check("en_off_an_bad", 32'(bad_an), 32'h0);
    check("en_off_seg_bad", 32'(bad_seg), 32'h0);
    en = 1'b1;
    step();
    check("en_on_an@551", 32'(an), 32'hD);
    check("en_on_seg@551", 32'(seg), 32'h24);

    // Reset during digit 2, with new digits waiting to be captured.
    while (k < 590) step();
    rst = 1'b1;
    digits = 16'h8765;
    step();
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_dp", 32'(dp_out), 32'h1);
    check("midrst_fd", 32'(frame_done), 32'h0);
    step();
    step();
    rst = 1'b0;
    k = 0;
    step();
    check("rerun_an@1", 32'(an), 32'hE);
    check("rerun_seg@1", 32'(seg), 32'h12);
    check("rerun_dp@1", 32'(dp_out), 32'h0);
    while (k < 33) step();
    check("rerun_an@33", 32'(an), 32'hD);
    check("rerun_seg@33", 32'(seg), 32'h02);
    check("rerun_dp@33", 32'(dp_out), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/disp_scan_mux.md
DISP_SCAN_MUX -- requirements
Module: disp_scan_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 Parameter DIVISOR, default 50000, clk cycles per scan tick (legal >= 2).
REQ-003 Parameter ACTIVE_LOW, default 1; 1 = anodes, segments and dp all active-low.
REQ-004 clk  in  1  system clock; one clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 digits  in  4*NUM_DIGITS  hex value per digit; digit k = bits [4k+3:4k].
REQ-007 dp  in  NUM_DIGITS  decimal point request per digit.
REQ-008 blank  in  NUM_DIGITS  per-digit blank; 1 = digit k never lit.
REQ-009 brightness  in  3  duty level 0..7.
REQ-010 en  in  1  display enable; 0 = all anodes inactive.
REQ-011 seg  out  7  segments a..g of current digit, registered.
REQ-012 dp_out  out  1  decimal point of current digit, registered.
REQ-013 an  out  NUM_DIGITS  one-hot (active level) anode select, registered.
REQ-014 frame_done  out  1  one-cycle pulse at each frame wrap.

Function
REQ-015 Prescaler counts 0..DIVISOR-1, wraps to 0; tick asserted the cycle count==DIVISOR-1.
REQ-016 Sub-slot counter sub (3 bits) increments on tick, wraps 7->0.
REQ-017 Digit index idx increments when tick and sub==7; wraps NUM_DIGITS-1 -> 0.
REQ-018 Slot length = 8*DIVISOR cycles; frame = NUM_DIGITS*8*DIVISOR cycles.
REQ-019 Frame wrap = tick && sub==7 && idx==NUM_DIGITS-1; frame_done high the cycle after it, exactly one cycle.
REQ-020 Snapshot registers (digits, dp, blank) load on first clk edge after rst deasserts and on every frame wrap; displayed data comes only from snapshot, never live inputs, so a frame is never torn.
REQ-021 Digit lit iff en==1 and snap_blank[idx]==0 and sub <= brightness; brightness 7 = 100% duty, 0 = 1/8 duty.
REQ-022 When lit: an has only bit idx active; else all an bits inactive.
REQ-023 seg = hex decode (0-F) of snap_digits[idx]; dp_out = snap_dp[idx]; both forced inactive when digit not lit.
REQ-024 Outputs lag internal state (idx, sub, en) by exactly one clk cycle.
REQ-025 brightness and en sampled live each cycle (not snapshotted); change takes effect next cycle.
REQ-026 No cycle with two anodes active, including at idx change and wrap.
REQ-027 Polarity: ACTIVE_LOW=1 => active level 0; ACTIVE_LOW=0 => active level 1, for an, seg, dp_out.

Reset
REQ-028 While rst high: count=0, sub=0, idx=0, snapshot=0 with snap_blank all 1, frame_done=0.
REQ-029 While rst high: an, seg, dp_out all at inactive level.
REQ-030 Reset asserted mid-frame takes effect next edge; scan restarts at idx 0, sub 0 on release.

Structure
REQ-031 Shared package/header holds 16-entry segment pattern constants (active-high a..g) and tick/slot width helpers.
REQ-032 One sub-module hex_seg_decoder: combinational 4-bit -> 7-bit active-high; polarity inversion applied in disp_scan_mux.
REQ-033 Counter widths derived from parameters via clog2; no fixed widths.

Verification (NUM_DIGITS=4, DIVISOR=4, ACTIVE_LOW=1)
REQ-034 Reset then digits=16'h4321, blank=0, brightness=7, en=1 -> an cycles 1110,1101,1011,0111 each 32 cycles; seg = codes 1,2,3,4; frame_done pulse every 128 cycles.
REQ-035 brightness=0 -> each anode active 4 of 32 slot cycles (sub==0), inactive remaining 28; seg all 1 while inactive.
REQ-036 Change digits to 16'hFFFF mid-frame -> current frame still shows 4321; F shown from next frame, aligned to frame_done.
REQ-037 blank=4'b0100, dp=4'b0001 -> digit 2 never lit; dp_out=0 only during digit 0 lit cycles.
REQ-038 en=0 for 50 cycles mid-slot -> an=1111 from next cycle; scan counters keep running, resume in phase.
REQ-039 Assert rst at idx 2 -> next edge an=1111, seg=7'h7F; after release scan restarts at digit 0 with new snapshot.
